// File: rtl/truth_table_pkg.sv
// rtl/truth_table_pkg.sv - shared types, sizes and row mapping for the truth-table sweeper
package truth_table_pkg;

   localparam int unsigned NUM_ROWS = 8;
   localparam int unsigned TABLE_W  = 8;
   localparam int unsigned ROW_W    = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_APPLY  = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Row {in1,in2,in3} lands in table bit (NUM_ROWS-1 - row): row 000 is the MSB.
   function automatic logic [ROW_W-1:0] row_to_bit(input logic [ROW_W-1:0] row);
      return ROW_W'(NUM_ROWS - 1) - row;
   endfunction

endpackage

// File: rtl/settle_timer.sv
// rtl/settle_timer.sv - loadable down-counter that flags the last cycle of a row hold
module settle_timer #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   output logic o_expire
);

   localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

   logic [CNT_W-1:0] r_count;

   // Reload with the hold length, then count down and park at zero.
   // Counting starts at SETTLE_CYCLES so the count reads 1 in the final hold cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= CNT_W'(SETTLE_CYCLES);
      end else if (r_count != '0) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign o_expire = (r_count == CNT_W'(1));

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - walks a 3-input gate through all 8 rows and reports its truth table
module truth_table_sweeper
   import truth_table_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [TABLE_W-1:0] expected,
   output logic               dut_in1,
   output logic               dut_in2,
   output logic               dut_in3,
   input  logic               dut_out,
   output logic               busy,
   output logic               done,
   output logic [TABLE_W-1:0] table_out,
   output logic               match,
   output logic [TABLE_W-1:0] mismatch_mask
);

   state_t             r_state;
   state_t             w_next_state;

   logic [ROW_W-1:0]   r_row;
   logic [ROW_W-1:0]   r_drive;
   logic [TABLE_W-1:0] r_expected;
   logic [TABLE_W-1:0] r_result;
   logic               r_busy;
   logic               r_done;
   logic [TABLE_W-1:0] r_table;
   logic               r_match;
   logic [TABLE_W-1:0] r_mask;

   logic               w_start;
   logic               w_load;
   logic               w_store;
   logic               w_advance;
   logic               w_finish;
   logic               w_cancel;
   logic               w_expire;
   logic [TABLE_W-1:0] w_result_next;

   settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle_timer (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_load),
      .o_expire (w_expire)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode and the datapath strobes it issues.
   // Abort beats start in IDLE; DONE always runs to completion and ignores abort.
   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_load       = 1'b0;
      w_store      = 1'b0;
      w_advance    = 1'b0;
      w_finish     = 1'b0;
      w_cancel     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start && !abort) begin
               w_next_state = ST_APPLY;
               w_start      = 1'b1;
               w_load       = 1'b1;
            end
         end
         ST_APPLY: begin
            if (abort) begin
               w_next_state = ST_IDLE;
               w_cancel     = 1'b1;
            end else if (w_expire) begin
               w_next_state = ST_SAMPLE;
            end
         end
         ST_SAMPLE: begin
            if (abort) begin
               w_next_state = ST_IDLE;
               w_cancel     = 1'b1;
            end else begin
               w_store = 1'b1;
               if (r_row == ROW_W'(NUM_ROWS - 1)) begin
                  w_next_state = ST_DONE;
                  w_finish     = 1'b1;
               end else begin
                  w_next_state = ST_APPLY;
                  w_load       = 1'b1;
                  w_advance    = 1'b1;
               end
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Result word with the current row's sample merged in, used on the sampling edge.
   always_comb begin
      w_result_next = r_result;
      w_result_next[row_to_bit(r_row)] = dut_out;
   end

   // Sweep datapath: row counter, gate drive, partial result and published results.
   // Published results only move on the edge that enters DONE, so abort and a
   // mid-sweep reset never expose a partial table.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_row      <= '0;
         r_drive    <= '0;
         r_expected <= '0;
         r_result   <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_table    <= '0;
         r_match    <= 1'b0;
         r_mask     <= '0;
      end else begin
         r_done <= w_finish;
         if (w_start) begin
            r_expected <= expected;
            r_row      <= '0;
            r_drive    <= '0;
            r_result   <= '0;
            r_busy     <= 1'b1;
         end
         if (w_store) begin
            r_result <= w_result_next;
         end
         if (w_advance) begin
            r_row   <= r_row + ROW_W'(1);
            r_drive <= r_row + ROW_W'(1);
         end
         if (w_finish) begin
            r_table <= w_result_next;
            r_match <= (w_result_next == r_expected);
            r_mask  <= w_result_next ^ r_expected;
         end
         if (w_finish || w_cancel) begin
            r_row   <= '0;
            r_drive <= '0;
            r_busy  <= 1'b0;
         end
      end
   end

   assign dut_in1       = r_drive[2];
   assign dut_in2       = r_drive[1];
   assign dut_in3       = r_drive[0];
   assign busy          = r_busy;
   assign done          = r_done;
   assign table_out     = r_table;
   assign match         = r_match;
   assign mismatch_mask = r_mask;

endmodule
